// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, register-zero constant and write-back entry type
package mips_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_REG_NUM = 5;

  localparam logic [DEF_REG_NUM-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DEF_REG_NUM-1:0] addr;
    logic [DEF_WIDTH-1:0]   data;
  } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - dual-push single-pop write-back queue with youngest-match lookup
module wb_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push0,
  input  logic [REG_NUM-1:0]         push0_addr,
  input  logic [WIDTH-1:0]           push0_data,
  input  logic                       push1,
  input  logic [REG_NUM-1:0]         push1_addr,
  input  logic [WIDTH-1:0]           push1_data,
  input  logic                       pop,
  output logic [REG_NUM-1:0]         head_addr,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [REG_NUM-1:0]         ra1,
  input  logic [REG_NUM-1:0]         ra2,
  output logic                       fwd1_hit,
  output logic [WIDTH-1:0]           fwd1_data,
  output logic                       fwd2_hit,
  output logic [WIDTH-1:0]           fwd2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_NUM-1:0] mem_addr [DEPTH];
  logic [WIDTH-1:0]   mem_data [DEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      idx;

  assign head_addr = mem_addr[rptr];
  assign head_data = mem_data[rptr];

  // Storage is not reset: entries are only meaningful below count, so reset discards them.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_addr[wptr] <= push0_addr;
      mem_data[wptr] <= push0_data;
    end
    if (push1) begin
      mem_addr[wptr + PW'(1)] <= push1_addr;
      mem_data[wptr + PW'(1)] <= push1_data;
    end
  end

  // Pointers wrap modulo DEPTH; push1 always lands one slot after push0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push0) + PW'(push1);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Walk valid entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count) begin
        if (ra1 != REG_NUM'(REG_ZERO) && mem_addr[idx] == ra1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[idx];
        end
        if (ra2 != REG_NUM'(REG_ZERO) && mem_addr[idx] == ra2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-source write-back arbiter driving the register-file write port
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_NUM-1:0]     a_addr,
  input  logic [WIDTH-1:0]       a_data,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [REG_NUM-1:0]     m_addr,
  input  logic [WIDTH-1:0]       m_data,
  output logic                   regwrite,
  output logic [REG_NUM-1:0]     wa,
  output logic [WIDTH-1:0]       wd,
  input  logic [REG_NUM-1:0]     ra1,
  input  logic [REG_NUM-1:0]     ra2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [WIDTH-1:0]       fwd1_data,
  output logic [WIDTH-1:0]       fwd2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      free;
  logic               need_a;
  logic               a_push;
  logic               m_push;
  logic               push0;
  logic               push1;
  logic [REG_NUM-1:0] push0_addr;
  logic [WIDTH-1:0]   push0_data;

  // The head drains every cycle, so its slot counts as free (pop-through).
  assign free     = CW'(DEPTH) - count + CW'(count != '0);
  assign need_a   = a_valid && (a_addr != REG_NUM'(REG_ZERO));
  assign a_ready  = (free >= CW'(1));
  assign m_ready  = (free >= CW'(1) + CW'(need_a));
  assign regwrite = (count != '0);

  // Drop register-0 writes after acknowledging them; A goes first so it keeps program order.
  always_comb begin
    a_push     = a_valid && a_ready && (a_addr != REG_NUM'(REG_ZERO));
    m_push     = m_valid && m_ready && (m_addr != REG_NUM'(REG_ZERO));
    push0      = a_push || m_push;
    push1      = a_push && m_push;
    push0_addr = a_push ? a_addr : m_addr;
    push0_data = a_push ? a_data : m_data;
  end

  wb_fifo #(
    .WIDTH   (WIDTH),
    .REG_NUM (REG_NUM),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (push0),
    .push0_addr (push0_addr),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_addr (m_addr),
    .push1_data (m_data),
    .pop        (regwrite),
    .head_addr  (wa),
    .head_data  (wd),
    .count      (count),
    .ra1        (ra1),
    .ra2        (ra2),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for the write-back arbiter
module tb_wb_arbiter;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_addr, m_addr;
  logic [31:0] a_data, m_data;
  logic        regwrite;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [2:0]  count;

  wb_entry sb[$];
  wb_entry exp_e;
  int n_checks = 0;
  int n_fail   = 0;

  logic fill_mr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int   fill_cnt[5] = '{2, 3, 4, 4, 4};

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH(32), .REG_NUM(5), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .regwrite  (regwrite),
    .wa        (wa),
    .wd        (wd),
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%0h, expected no write at %0t", wa, wd, $time);
      end else begin
        exp_e = sb.pop_front();
        chk("wb_addr", 32'(wa), 32'(exp_e.addr));
        chk("wb_data", wd, exp_e.data);
      end
    end
  end

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    a_valid = av; a_addr = aa; a_data = ad;
    m_valid = mv; m_addr = ma; m_data = md;
  endtask

  task automatic finish_cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md,
                            input logic er_a, input logic er_m);
    chk("a_ready", 32'(a_ready), 32'(er_a));
    chk("m_ready", 32'(m_ready), 32'(er_m));
    if (av && er_a && aa != 5'd0) sb.push_back('{addr: aa, data: ad});
    if (mv && er_m && ma != 5'd0) sb.push_back('{addr: ma, data: md});
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic er_a, input logic er_m);
    drive(av, aa, ad, mv, ma, md);
    @(negedge clk);
    finish_cyc(av, aa, ad, mv, ma, md, er_a, er_m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mi;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ra1 = 5'd9;
    ra2 = 5'd0;
    #3;
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_m_ready", 32'(m_ready), 32'd1);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write
    cyc(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    chk("single_regwrite", 32'(regwrite), 32'd1);
    chk("single_wa", 32'(wa), 32'd5);
    chk("single_count", 32'(count), 32'd1);
    idle(1);
    chk("single_drained", 32'(count), 32'd0);

    // Dual push, A then M
    cyc(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 1'b1);
    chk("dual_count2", 32'(count), 32'd2);
    chk("dual_head", 32'(wa), 32'd3);
    idle(1);
    chk("dual_count1", 32'(count), 32'd1);
    chk("dual_second", 32'(wa), 32'd7);
    idle(1);
    chk("dual_count0", 32'(count), 32'd0);

    // Register 0 from A is acked but dropped; M accepted with needA = 0
    cyc(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd8, 32'hC, 1'b1, 1'b1);
    chk("r0_count", 32'(count), 32'd1);
    chk("r0_wa", 32'(wa), 32'd8);
    idle(1);
    chk("r0_drained", 32'(count), 32'd0);

    // Fill: both sources every cycle, M held while blocked
    mi = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + mi), 32'h200 + 32'(mi),
          1'b1, fill_mr[i]);
      if (fill_mr[i]) mi++;
      chk("fill_count", 32'(count), 32'(fill_cnt[i]));
    end
    idle(4);
    chk("fill_drained", 32'(count), 32'd0);

    // Forwarding: youngest r9 wins, incoming requests not searched
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    @(negedge clk);
    chk("fwd_incoming_hit", 32'(fwd1_hit), 32'd0);
    finish_cyc(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b1, 1'b1);
    chk("fwd_count", 32'(count), 32'd2);
    chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("fwd1_data", fwd1_data, 32'h2);
    chk("fwd2_hit", 32'(fwd2_hit), 32'd0);
    chk("fwd2_data", fwd2_data, 32'h0);
    idle(1);
    chk("fwd1_hit_tail", 32'(fwd1_hit), 32'd1);
    chk("fwd1_data_tail", fwd1_data, 32'h2);
    idle(1);
    chk("fwd1_hit_drained", 32'(fwd1_hit), 32'd0);

    // Reset mid-burst with 3 entries queued
    cyc(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 1'b1, 1'b1);
    cyc(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 1'b1, 1'b1);
    chk("burst_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", 32'(regwrite), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_m_ready", 32'(m_ready), 32'd1);
    chk("midrst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    chk("postrst_count", 32'(count), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting in front of the register file's single write port (regwrite/wa/wd). Accepts write-back requests from the ALU pipe (source A) and from the load/mul-div unit (source M) through valid/ready handshakes. Queues them in order in a small FIFO and drains one write per cycle into the register file. Exposes a forwarding lookup so decode can read values that are still queued and not yet in the register file.

## Interface
Parameters:
- WIDTH, 32, data width
- REG_NUM, 5, register address width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_valid  in  1  source A request valid
- a_ready  out  1  source A request accepted this cycle
- a_addr  in  REG_NUM  source A destination register
- a_data  in  WIDTH  source A write data
- m_valid, m_ready, m_addr, m_data: same as source A, for source M
- regwrite  out  1  register-file write enable
- wa  out  REG_NUM  register-file write address
- wd  out  WIDTH  register-file write data
- ra1, ra2  in  REG_NUM  forwarding lookup addresses (decode read ports)
- fwd1_hit, fwd2_hit  out  1  a queued write exists for ra1 / ra2
- fwd1_data, fwd2_data  out  WIDTH  data of the youngest queued write to ra1 / ra2
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- FIFO of {addr, data}. Head drives wa/wd combinationally; regwrite = (count != 0).
- Pop: every cycle with count != 0. The register file captures head at that edge; no back-pressure from the register file.
- free = DEPTH − count + (count != 0). Pop-through is allowed.
- a_ready = (free ≥ 1).
- m_ready = (free ≥ 1 + needA), where needA = a_valid && a_addr != 0.
- Push order within a cycle: A enqueued before M. This is the program order.
- Writes to register 0 are acknowledged (ready per the rules above) but never enqueued. They never appear on regwrite.
- Both sources may push in the same cycle. The net count change is pushes − pop, within [−1, +2].
- Forwarding is combinational:
  - The lookup searches all valid entries, including the head.
  - The youngest match wins.
  - ra == 0 always gives hit = 0, data = 0.
  - Incoming requests in the current cycle are not searched.
- Ordering guarantee: for any register, writes reach the register file in acceptance order.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0; read/write pointers = 0.
  - regwrite = 0; wa and wd are don't-care.
  - a_ready = m_ready = 1; fwd*_hit = 0.
  - Queued writes are discarded, not flushed.
- Reset mid-operation: outputs take their reset values immediately, independent of clk.
- Latency: request accepted at edge N (count was 0) → regwrite = 1 during cycle N..N+1 → register file written at edge N+1.
- Throughput: 1 write per cycle sustained. Bursts of 2 per cycle are absorbed until full.
- Full with pop: when count = DEPTH, free = 1, so A can still be accepted and M is blocked.
- Pointer wrap-around is modulo DEPTH with no bubble.
- Handshake: a transfer occurs only on an edge with valid && ready. Sources hold addr/data stable while valid && !ready.

## Structure
- Shared package `mips_pkg`:
  - WIDTH and REG_NUM defaults.
  - REG_ZERO constant (5'd0).
  - A wb_entry type {addr, data}.
- Sub-module `wb_fifo`:
  - Storage array, pointers, count, push0/push1/pop logic.
  - Parallel youngest-match search for two lookup ports.
- Top level: ready computation, register-0 filtering, push steering, regfile port drive.

## Test plan
- Single write: a_valid with r5 = 0x00001234 → next cycle regwrite = 1, wa = 5, wd = 0x00001234; count returns to 0 after one cycle.
- Dual push: A r3 = 0xA and M r7 = 0xB in the same cycle → two consecutive regwrite cycles, r3 then r7; count peaks at 2.
- Register 0: a_valid, a_addr = 0, data 0xFFFF → a_ready = 1, no regwrite, count unchanged; M in the same cycle is accepted with needA = 0.
- Fill: DEPTH = 4, both sources valid every cycle with distinct addresses → count reaches 4, then m_ready = 0 while a_ready = 1; all accepted writes emerge in order, one per cycle, none lost or duplicated.
- Forwarding: queue r9 = 0x1, then r9 = 0x2, with ra1 = 9 and ra2 = 0 → fwd1_hit = 1, fwd1_data = 0x2; fwd2_hit = 0. After both writes drain, fwd1_hit = 0.
- Reset mid-burst: 3 entries queued, rst_n pulsed low between edges → regwrite = 0 and count = 0 immediately; after release, no writes are issued.
